// File: rtl/tile_sequencer_if.sv
// Tile sequencer bus: command handshake, unified-memory port and MMU port.
//   master modport: the sequencer (drives strobes/data toward memory and MMU)
//   slave  modport: the environment (control unit, memory, MMU)
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_addr  command handshake and fields
//   mem_rd_en/mem_wr_en/mem_addr         memory strobes and address
//   mem_rd_data/mem_wr_data              memory read/write rows
//   weight_data/weight_valid/weight_row  weight rows to the MMU
//   input_data/input_valid               skewed input lanes to the MMU
//   acc_rd_en/acc_row/acc_data           accumulator row readback
//   busy/done/err                        status
interface tile_sequencer_if #(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 13
);
  localparam int unsigned RowW = $clog2(N);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [ADDR_W-1:0]   cmd_addr;
  logic                mem_rd_en;
  logic                mem_wr_en;
  logic [ADDR_W-1:0]   mem_addr;
  logic [N*DATA_W-1:0] mem_rd_data;
  logic [N*DATA_W-1:0] mem_wr_data;
  logic [N*DATA_W-1:0] weight_data;
  logic                weight_valid;
  logic [RowW-1:0]     weight_row;
  logic [N*DATA_W-1:0] input_data;
  logic [N-1:0]        input_valid;
  logic                acc_rd_en;
  logic [RowW-1:0]     acc_row;
  logic [N*DATA_W-1:0] acc_data;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, mem_rd_data, acc_data,
    output cmd_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
           weight_data, weight_valid, weight_row, input_data, input_valid,
           acc_rd_en, acc_row, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, mem_rd_data, acc_data,
    input  cmd_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
           weight_data, weight_valid, weight_row, input_data, input_valid,
           acc_rd_en, acc_row, busy, done, err
  );
endinterface

// File: rtl/tile_sequencer.sv
// Tile sequencer: runs one LOAD_WEIGHT / LOAD_INPUT / STORE command at a time.
// Loads read N memory rows (base+r); weights go straight to the MMU, input rows
// are diagonally skewed (lane j delayed j cycles). STORE reads N accumulator
// rows and writes them to memory at base+r. Opcode 00 only pulses err.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset; all outputs forced to 0 while high
//   bus    tile_sequencer_if.master (command, memory and MMU signals)
module tile_sequencer #(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 13
) (
  input logic                 clk,
  input logic                 reset,
  tile_sequencer_if.master    bus
);
  localparam int unsigned RowW    = $clog2(N);
  localparam int unsigned CntW    = $clog2(N + 1);
  localparam int unsigned SkewLen = N * (N - 1) / 2;

  typedef enum logic [2:0] {StIdle, StRead, StStoreRd, StDrain, StDone} state_e;
  typedef enum logic [1:0] {
    OpRsvd  = 2'b00,
    OpLoadW = 2'b01,
    OpLoadI = 2'b10,
    OpStore = 2'b11
  } op_e;

  // Lane j (j >= 1) owns skew stages [lane_off(j), lane_off(j)+j-1].
  function automatic int unsigned lane_off(input int unsigned j);
    return j * (j - 1) / 2;
  endfunction

  state_e                    state_q, state_d;
  op_e                       op_q, op_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [CntW-1:0]           cnt_q, cnt_d;     // rows already issued
  logic [CntW-1:0]           drain_q, drain_d;
  logic                      mem_rd_en_q, mem_rd_en_d;
  logic                      mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic                      acc_rd_en_q, acc_rd_en_d;
  logic [RowW-1:0]           acc_row_q, acc_row_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      rd_vld_q, rd_vld_d;  // mem_rd_data holds a requested row
  logic [RowW-1:0]           rd_row_q, rd_row_d;
  logic [N-2:0]              iv_q, iv_d;          // iv_q[k]: input valid delayed k+1
  logic [SkewLen*DATA_W-1:0] skew_q, skew_d;

  logic         in_vld;
  logic         wv;
  logic [N-1:0] lane_vld;

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    mem_rd_en_d = 1'b0;
    acc_rd_en_d = 1'b0;
    acc_row_d   = acc_row_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_addr_d  = mem_addr_q;
    rd_vld_d    = mem_rd_en_q;
    // Rows always return in order 0..N-1, so the index just counts valid beats.
    rd_row_d    = rd_vld_q ? rd_row_q + RowW'(1) : '0;
    // Accumulator row read last cycle is written back this cycle.
    mem_wr_en_d = acc_rd_en_q;
    if (acc_rd_en_q) begin
      mem_addr_d = base_q + ADDR_W'(acc_row_q);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          op_d   = op_e'(bus.cmd_op);
          base_d = bus.cmd_addr;
          unique case (op_e'(bus.cmd_op))
            OpRsvd: err_d = 1'b1;
            OpStore: begin
              state_d     = StStoreRd;
              acc_rd_en_d = 1'b1;
              acc_row_d   = '0;
              cnt_d       = CntW'(1);
            end
            default: begin
              state_d     = StRead;
              mem_rd_en_d = 1'b1;
              mem_addr_d  = bus.cmd_addr;
              cnt_d       = CntW'(1);
            end
          endcase
        end
      end
      StRead: begin
        if (cnt_q == CntW'(N)) begin
          state_d = StDrain;
          // Input lanes need N-1 extra cycles for the deepest skew stage.
          drain_d = (op_q == OpLoadI) ? CntW'(N - 1) : '0;
        end else begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = base_q + ADDR_W'(cnt_q);
          cnt_d       = cnt_q + CntW'(1);
        end
      end
      StStoreRd: begin
        if (cnt_q == CntW'(N)) begin
          state_d = StDrain;
          drain_d = '0;
        end else begin
          acc_rd_en_d = 1'b1;
          acc_row_d   = RowW'(cnt_q);
          cnt_d       = cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Skew pipelines shift every cycle; output gating by lane valid hides stale data.
  always_comb begin
    in_vld = rd_vld_q && (op_q == OpLoadI);
    iv_d   = iv_q;
    iv_d[0] = in_vld;
    for (int unsigned k = 1; k < N - 1; k++) begin
      iv_d[k] = iv_q[k-1];
    end
    skew_d = skew_q;
    for (int unsigned j = 1; j < N; j++) begin
      skew_d[lane_off(j)*DATA_W +: DATA_W] = bus.mem_rd_data[j*DATA_W +: DATA_W];
      for (int unsigned s = 1; s < j; s++) begin
        skew_d[(lane_off(j)+s)*DATA_W +: DATA_W] =
          skew_q[(lane_off(j)+s-1)*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= OpRsvd;
      base_q      <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      mem_rd_en_q <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      acc_rd_en_q <= 1'b0;
      acc_row_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_row_q    <= '0;
      iv_q        <= '0;
      skew_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      acc_rd_en_q <= acc_rd_en_d;
      acc_row_q   <= acc_row_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_vld_q    <= rd_vld_d;
      rd_row_q    <= rd_row_d;
      iv_q        <= iv_d;
      skew_q      <= skew_d;
    end
  end

  // Outputs: registered state, forced to 0 while reset is asserted.
  always_comb begin
    wv       = !reset && rd_vld_q && (op_q == OpLoadW);
    lane_vld = '0;
    lane_vld[0] = !reset && in_vld;
    for (int unsigned j = 1; j < N; j++) begin
      lane_vld[j] = !reset && iv_q[j-1];
    end

    bus.cmd_ready    = !reset && (state_q == StIdle);
    bus.busy         = !reset && (state_q != StIdle);
    bus.done         = !reset && done_q;
    bus.err          = !reset && err_q;
    bus.mem_rd_en    = !reset && mem_rd_en_q;
    bus.mem_wr_en    = !reset && mem_wr_en_q;
    bus.mem_addr     = reset ? '0 : mem_addr_q;
    bus.mem_wr_data  = (!reset && mem_wr_en_q) ? bus.acc_data : '0;
    bus.acc_rd_en    = !reset && acc_rd_en_q;
    bus.acc_row      = reset ? '0 : acc_row_q;
    bus.weight_valid = wv;
    bus.weight_data  = wv ? bus.mem_rd_data : '0;
    bus.weight_row   = wv ? rd_row_q : '0;
    bus.input_valid  = lane_vld;

    bus.input_data = '0;
    if (lane_vld[0]) begin
      bus.input_data[DATA_W-1:0] = bus.mem_rd_data[DATA_W-1:0];
    end
    for (int unsigned j = 1; j < N; j++) begin
      if (lane_vld[j]) begin
        bus.input_data[j*DATA_W +: DATA_W] = skew_q[(lane_off(j)+j-1)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- Executes one tile-level datapath command at a time: LOAD_WEIGHT, LOAD_INPUT or STORE, each carrying a base_address.
- Sits between the instruction control unit, the unified memory and the N x N systolic MMU.
- Load commands read N memory rows; input rows go to the array with per-lane diagonal skew.
- STORE reads N accumulator rows from the MMU and writes them to memory.

Parameters:
- N, 2, systolic array dimension (rows per tile, lanes per row); N >= 2.
- DATA_W, 8, bits per lane element.
- ADDR_W, 13, memory address width (matches base_address).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  01 LOAD_WEIGHT, 10 LOAD_INPUT, 11 STORE, 00 reserved
- cmd_addr  in  ADDR_W  tile base address
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address for the read or write
- mem_rd_data  in  N*DATA_W  read row; valid the cycle after mem_rd_en
- mem_wr_data  out  N*DATA_W  write row
- weight_data  out  N*DATA_W  weight row to MMU
- weight_valid  out  1  weight_data valid
- weight_row  out  $clog2(N)  row index of weight_data
- input_data  out  N*DATA_W  skewed input lanes; lane j = bits [j*DATA_W +: DATA_W]
- input_valid  out  N  per-lane valid
- acc_rd_en  out  1  accumulator row read strobe
- acc_row  out  $clog2(N)  accumulator row index
- acc_data  in  N*DATA_W  accumulator row; valid the cycle after acc_rd_en
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- err  out  1  one-cycle pulse for a reserved opcode

Behaviour:
- Reset, synchronous:
  - State goes to IDLE; row counter cleared; all skew and valid pipelines flushed.
  - Every output is 0, including cmd_ready while reset is high.
  - Reset mid-command aborts it: no done, and in-flight read data is discarded.
- State machine: IDLE, READ, STORE_RD, DRAIN, DONE.
  - cmd_ready = 1 only in IDLE with reset low.
  - Accept happens when cmd_valid && cmd_ready. cmd_op and cmd_addr are latched and row counter r is set to 0.
- Timing convention: cycle 0 is the accept cycle. All strobes, done and err are registered.
- Address arithmetic: address = latched_addr + r, modulo 2^ADDR_W, so it wraps silently.
- LOAD_WEIGHT (IDLE->READ->DRAIN->DONE->IDLE):
  - Cycles 1..N: mem_rd_en=1, mem_addr = base+r.
  - Cycles 2..N+1: weight_valid=1, weight_data = mem_rd_data, weight_row = r (row order 0..N-1).
  - done=1 in cycle N+2.
- LOAD_INPUT (IDLE->READ->DRAIN->DONE->IDLE):
  - Reads happen as for LOAD_WEIGHT.
  - Lane j of row r is presented in cycle 2+r+j, delayed by j register stages per lane.
  - input_valid[j] is high for cycles 2+j..N+1+j. Lanes outside their window drive data 0.
  - done=1 in cycle 2N+1.
- STORE (IDLE->STORE_RD->DRAIN->DONE->IDLE):
  - Cycles 1..N: acc_rd_en=1, acc_row = r.
  - Cycles 2..N+1: mem_wr_en=1, mem_addr = base+r, mem_wr_data = acc_data.
  - mem_rd_en stays 0 throughout. done=1 in cycle N+2.
- Reserved op 00: accepted, err=1 in cycle 1, no memory or MMU activity, stays in IDLE.
- busy = 1 from cycle 1 through the done cycle inclusive. cmd_ready = 0 over the same span.
  - The earliest next accept is the cycle after done.
- mem_rd_en and mem_wr_en are never high in the same cycle. weight_valid and input_valid are never high simultaneously.
- cmd_valid held high while busy has no effect. Fields change without a handshake are ignored.

Test Plan:
- Reset, then idle: all outputs 0 during reset; cmd_ready=1 the cycle after reset deasserts.
- LOAD_WEIGHT, N=2, addr 0x000F, memory rows {0x0201, 0x0403}:
  - mem_addr 0x000F then 0x0010 in cycles 1-2.
  - weight_valid in cycles 2-3 with rows 0x0201 then 0x0403 and weight_row 0,1.
  - done in cycle 4.
- LOAD_INPUT, N=2, addr 0x001E, rows {0x0B0A, 0x0D0C}:
  - lane0 gives 0x0A in cycle 2 and 0x0C in cycle 3.
  - lane1 gives 0x0B in cycle 3 and 0x0D in cycle 4.
  - input_valid = 01, 11, 10 over cycles 2-4; done in cycle 5.
- STORE, addr 0x0007, acc rows {0x1111, 0x2222}:
  - acc_row 0,1 in cycles 1-2.
  - mem_wr_en in cycles 2-3 at 0x0007 and 0x0008 with data 0x1111 and 0x2222.
  - done in cycle 4.
- Wrap and back-to-back:
  - LOAD_WEIGHT at 0x1FFF reads 0x1FFF then 0x0000.
  - A second command held on cmd_valid is accepted the cycle after done.
  - An op=00 command gives err in cycle 1, no strobes, cmd_ready stays 1.
- Reset in cycle 2 of LOAD_INPUT: all valids and strobes are 0 the next cycle, no done, and a fresh command executes normally afterwards.
